gf180mcu_fd_io__pwrseq: RTL and testbench

Synchronous power-up/power-down sequencer for a GF180MCU pad ring, i.e. the segment bounded by corner cells sharing DVDD/DVSS/VDD/VSS.
- Debounces the DVDD-good and VDD-good indications from the ring's supply detectors.
- Then releases core/IO isolation, input enables, output enables and the ring POR in a fixed order.
- Tears these down in reverse order on a power-down request.
- Forces a safe state on supply loss.
- Sits in the always-on domain between the supply detectors and the pad-ring control nets.

---
 rtl/gf180mcu_fd_io__pwrseq.sv | 138 +++++++++++++
 tb/tb_gf180mcu_fd_io__pwrseq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_io__pwrseq.sv
// Always-on power sequencer for one GF180MCU pad-ring segment: debounces the
// supply-good detectors, then releases isolation, IE, OE and POR in order.
module gf180mcu_fd_io__pwrseq #(
    parameter int DEB_CYCLES  = 16,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       DVDD_OK,
    input  logic       VDD_OK,
    input  logic       PD_REQ,
    input  logic       FAULT_CLR,
    output logic       ISO_N,
    output logic       IE_EN,
    output logic       OE_EN,
    output logic       POR_N,
    output logic       READY,
    output logic       FAULT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_DEB_DVDD = 3'd1,
        S_DEB_VDD  = 3'd2,
        S_REL_ISO  = 3'd3,
        S_EN_IE    = 3'd4,
        S_UP       = 3'd5,
        S_PDN      = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    state_t           state;
    state_t           nstate;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ncnt;
    logic             phase;
    logic             nphase;
    logic             supply_lost;

    assign supply_lost = !DVDD_OK || !VDD_OK;
    assign STATE       = state;

    // Output pattern {ISO_N, IE_EN, OE_EN, POR_N, READY, FAULT} for a state.
    // PDN splits into two halves so IE_EN drops half-way through teardown.
    function automatic logic [5:0] decode(input state_t s, input logic ph);
        logic [5:0] o;
        o = 6'b000000;
        case (s)
            S_REL_ISO: o = 6'b100000;
            S_EN_IE:   o = 6'b110000;
            S_UP:      o = 6'b111110;
            S_PDN:     o = ph ? 6'b100100 : 6'b110100;
            S_FAULT:   o = 6'b000001;
            default:   o = 6'b000000;
        endcase
        return o;
    endfunction

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nphase = phase;
        case (state)
            S_OFF: begin
                if (DVDD_OK && !PD_REQ) nstate = S_DEB_DVDD;
            end
            S_DEB_DVDD: begin
                if (!DVDD_OK || PD_REQ)  nstate = S_OFF;
                else if (cnt == DEB_LAST) nstate = S_DEB_VDD;
                else                      ncnt = cnt + 1'b1;
            end
            S_DEB_VDD: begin
                // A VDD dropout restarts the window without abandoning DVDD.
                if (!DVDD_OK || PD_REQ)  nstate = S_OFF;
                else if (!VDD_OK)         ncnt = '0;
                else if (cnt == DEB_LAST) nstate = S_REL_ISO;
                else                      ncnt = cnt + 1'b1;
            end
            S_REL_ISO: begin
                if (supply_lost)           nstate = S_FAULT;
                else if (cnt == STEP_LAST) nstate = S_EN_IE;
                else                       ncnt = cnt + 1'b1;
            end
            S_EN_IE: begin
                if (supply_lost)           nstate = S_FAULT;
                else if (cnt == STEP_LAST) nstate = S_UP;
                else                       ncnt = cnt + 1'b1;
            end
            S_UP: begin
                if (supply_lost) nstate = S_FAULT;
                else if (PD_REQ) nstate = S_PDN;
            end
            S_PDN: begin
                // Losing supply during an intended shutdown is not a fault.
                if (supply_lost) begin
                    nstate = S_OFF;
                end else if (cnt == STEP_LAST) begin
                    if (phase) begin
                        nstate = S_OFF;
                    end else begin
                        nphase = 1'b1;
                        ncnt   = '0;
                    end
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            S_FAULT: begin
                if (FAULT_CLR) nstate = S_OFF;
            end
            default: nstate = S_OFF;
        endcase
        if (nstate != state) begin
            ncnt   = '0;
            nphase = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state <= S_OFF;
            cnt   <= '0;
            phase <= 1'b0;
            {ISO_N, IE_EN, OE_EN, POR_N, READY, FAULT} <= 6'b000000;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            phase <= nphase;
            {ISO_N, IE_EN, OE_EN, POR_N, READY, FAULT} <= decode(nstate, nphase);
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_io__pwrseq.sv
// Scoreboard bench for the pad-ring power sequencer: directed vectors queue
// expected {STATE, ISO_N, IE_EN, OE_EN, POR_N, READY, FAULT} per edge.
module tb_gf180mcu_fd_io__pwrseq;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       dvdd_ok = 1'b0;
    logic       vdd_ok = 1'b0;
    logic       pd_req = 1'b0;
    logic       fault_clr = 1'b0;
    logic       iso_n, ie_en, oe_en, por_n, ready, fault;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t ent;

    // {STATE, ISO_N, IE_EN, OE_EN, POR_N, READY, FAULT}
    localparam logic [8:0] E_OFF = {3'd0, 6'b000000};
    localparam logic [8:0] E_DD  = {3'd1, 6'b000000};
    localparam logic [8:0] E_DV  = {3'd2, 6'b000000};
    localparam logic [8:0] E_RI  = {3'd3, 6'b100000};
    localparam logic [8:0] E_IE  = {3'd4, 6'b110000};
    localparam logic [8:0] E_UP  = {3'd5, 6'b111110};
    localparam logic [8:0] E_PD0 = {3'd6, 6'b110100};
    localparam logic [8:0] E_PD1 = {3'd6, 6'b100100};
    localparam logic [8:0] E_FT  = {3'd7, 6'b000001};

    gf180mcu_fd_io__pwrseq #(
        .DEB_CYCLES (4),
        .STEP_CYCLES(2),
        .CNT_W      (4)
    ) dut (
        .CLK      (clk),
        .RN       (rn),
        .DVDD_OK  (dvdd_ok),
        .VDD_OK   (vdd_ok),
        .PD_REQ   (pd_req),
        .FAULT_CLR(fault_clr),
        .ISO_N    (iso_n),
        .IE_EN    (ie_en),
        .OE_EN    (oe_en),
        .POR_N    (por_n),
        .READY    (ready),
        .FAULT    (fault),
        .STATE    (state)
    );

    always #5 clk = ~clk;

    // Monitor: every edge presents a new output word; compare against the
    // expectation queued for that edge, and check the structural invariants.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            ent = q.pop_front();
            tests++;
            if ({state, iso_n, ie_en, oe_en, por_n, ready, fault} !== ent.v) begin
                fails++;
                $display("FAIL %s: got %b required %b", ent.name,
                         {state, iso_n, ie_en, oe_en, por_n, ready, fault}, ent.v);
            end
        end
        tests++;
        if (!((!oe_en || ie_en) && (!ie_en || iso_n) &&
              (ready === (state == 3'd5)) && (fault === (state == 3'd7)))) begin
            fails++;
            $display("FAIL invariant: state=%0d iso_n=%b ie_en=%b oe_en=%b ready=%b fault=%b",
                     state, iso_n, ie_en, oe_en, ready, fault);
        end
    end

    task automatic cyc(input logic rn_i, input logic dv, input logic vd,
                       input logic pd, input logic fc, input logic [8:0] e,
                       input string nm);
        exp_t x;
        @(negedge clk);
        rn = rn_i; dvdd_ok = dv; vdd_ok = vd; pd_req = pd; fault_clr = fc;
        x.v = e;
        x.name = nm;
        q.push_back(x);
    endtask

    // Clean power-up from OFF with both supplies good: 13 edges to UP.
    task automatic bringup();
        for (int i = 0; i < 13; i++) begin
            logic [8:0] e;
            if (i < 4)       e = E_DD;
            else if (i < 8)  e = E_DV;
            else if (i < 10) e = E_RI;
            else if (i < 12) e = E_IE;
            else             e = E_UP;
            cyc(1, 1, 1, 0, 0, e, "bringup");
        end
    endtask

    initial begin
        // Reset with supplies present
        cyc(0, 1, 1, 0, 0, E_OFF, "reset");
        cyc(0, 1, 1, 0, 0, E_OFF, "reset");
        bringup();
        cyc(1, 1, 1, 0, 0, E_UP, "up_hold");
        cyc(1, 1, 1, 0, 1, E_UP, "clr_ignored_up");

        // Orderly power-down, OFF held while request stays high
        cyc(1, 1, 1, 1, 0, E_PD0, "pdn_oe_off");
        cyc(1, 1, 1, 1, 0, E_PD0, "pdn_step0");
        cyc(1, 1, 1, 0, 0, E_PD1, "pdn_ie_off");
        cyc(1, 1, 1, 0, 0, E_PD1, "pdn_step1");
        cyc(1, 1, 1, 1, 0, E_OFF, "pdn_done");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0, E_OFF, "pd_hold_off");

        // DVDD glitch on third debounce cycle restarts debounce
        cyc(1, 1, 1, 0, 0, E_DD, "deb_start");
        cyc(1, 1, 1, 0, 0, E_DD, "deb_cnt");
        cyc(1, 0, 1, 0, 0, E_OFF, "dvdd_glitch");
        bringup();

        // Supply loss from UP, fault hold, clear, resequence
        cyc(1, 1, 0, 0, 0, E_FT, "vdd_loss");
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, E_FT, "fault_hold");
        cyc(1, 1, 1, 0, 1, E_OFF, "fault_clr");
        bringup();

        // Supply loss beats power-down request
        cyc(1, 1, 0, 1, 0, E_FT, "loss_beats_pd");
        cyc(1, 1, 1, 0, 1, E_OFF, "fault_clr2");
        bringup();

        // Supply loss mid power-down is not a fault
        cyc(1, 1, 1, 1, 0, E_PD0, "pdn_enter");
        cyc(1, 0, 1, 1, 0, E_OFF, "pdn_loss");

        // VDD dropout during VDD debounce restarts only that window
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, E_DD, "deb_dvdd");
        cyc(1, 1, 1, 0, 0, E_DV, "deb_vdd");
        cyc(1, 1, 0, 0, 0, E_DV, "vdd_stall");
        cyc(1, 1, 0, 0, 0, E_DV, "vdd_stall");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, E_DV, "vdd_recount");
        cyc(1, 1, 1, 0, 0, E_RI, "rel_iso");
        cyc(1, 1, 1, 0, 0, E_RI, "rel_iso_hold");
        cyc(1, 1, 1, 0, 0, E_IE, "en_ie");

        // Reset in EN_IE, then power-down request during debounce
        cyc(0, 1, 1, 0, 0, E_OFF, "reset_mid");
        cyc(0, 1, 1, 0, 0, E_OFF, "reset_hold");
        cyc(1, 1, 1, 0, 0, E_DD, "deb_again");
        cyc(1, 1, 1, 1, 0, E_OFF, "pd_in_deb");

        // Random soak; only the monitor invariants apply here
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rn        = ($urandom_range(0, 499) != 0);
            dvdd_ok   = ($urandom_range(0, 39) != 0);
            vdd_ok    = ($urandom_range(0, 39) != 0);
            pd_req    = ($urandom_range(0, 15) == 0);
            fault_clr = ($urandom_range(0, 3) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
